sccb_master: RTL and testbench

SCCB/I2C byte-level master for OV5640 register access. It sits directly downstream of the camera configuration sequencer. It accepts one 32-bit command {device ID, 16-bit register address, 8-bit value}, serialises it on open-drain SCL/SDA, and reports completion through `busy`. It performs a 3-phase write, or a 2-phase-write plus 2-phase-read when ID bit 0 is set.

---
 rtl/sccb_pkg.sv | 16 +
 rtl/sccb_master_if.sv | 10 +
 rtl/sccb_tick_gen.sv | 25 ++
 rtl/sccb_master.sv | 100 ++++++++++
 tb/tb_sccb_master.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared states, slot constants and command field positions for the SCCB master
package sccb_pkg;
  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} state_t;
  localparam int WR_SLOTS = 38;
  localparam int RD_SLOTS = 49;
  localparam int QUARTERS = 4;
  localparam int ID_POS = 24;
  localparam int REG_H_POS = 16;
  localparam int REG_L_POS = 8;
  localparam int VAL_POS = 0;
  function automatic logic [7:0] byte_sel(input logic [31:0] c, input logic ph, input logic [1:0] i);
    return i == 2'd0 ? {c[ID_POS+1 +: 7], ph & c[ID_POS]} :
           i == 2'd1 ? c[REG_H_POS +: 8] :
           i == 2'd2 ? c[REG_L_POS +: 8] : c[VAL_POS +: 8];
  endfunction
endpackage

// File: rtl/sccb_master_if.sv
// sccb_master_if: command/status handshake between the config sequencer (master) and sccb_master (slave)
interface sccb_master_if;
  logic start;
  logic [31:0] wdata;
  logic [7:0] riic_data;
  logic busy;
  logic ack_err;
  modport master (output start, wdata, input riic_data, busy, ack_err);
  modport slave (input start, wdata, output riic_data, busy, ack_err);
endinterface

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: QDIV-cycle quarter timer with 2-bit quarter index, held at zero while clr
module sccb_tick_gen #(
  parameter int QDIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic q_tick,
  output logic q_first,
  output logic [1:0] quarter
);
  localparam int CW = QDIV > 1 ? $clog2(QDIV) : 1;
  logic [CW-1:0] cnt;
  assign q_tick = cnt == CW'(QDIV - 1);
  assign q_first = cnt == '0;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      quarter <= '0;
    end else begin
      cnt <= q_tick ? '0 : cnt + CW'(1);
      quarter <= q_tick ? quarter + 2'd1 : quarter;
    end
  end
endmodule

// File: rtl/sccb_master.sv
// sccb_master: SCCB/I2C register write/read master for OV5640; define SCCB_ACK_CHECK_EN to end on slave NACK
module sccb_master
  import sccb_pkg::*;
#(
  parameter int QDIV = 125
) (
  input  logic sclk,
  input  logic s_rst,
  output logic iic_scl,
  inout  wire  iic_sda,
  sccb_master_if.slave cmd
);
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif
  state_t state, state_n;
  logic [31:0] cmd_r;
  logic [7:0] cur_byte, riic_q;
  logic [6:0] rx;
  logic [2:0] bit_cnt;
  logic [1:0] idx, last, quarter;
  logic phase, ack_err_q, q_tick, q_first, slot_end, sample, rd, rd_byte, nack, abort, sda_low;
  sccb_tick_gen #(.QDIV(QDIV)) u_tick (
    .clk(sclk), .rst(s_rst), .clr(state == IDLE),
    .q_tick(q_tick), .q_first(q_first), .quarter(quarter)
  );
  assign rd = cmd_r[ID_POS];
  assign slot_end = q_tick && quarter == 2'(QUARTERS - 1);
  assign sample = q_first && quarter == 2'(QUARTERS - 1);
  assign rd_byte = phase && idx == 2'd1;
  assign last = phase ? 2'd1 : rd ? 2'd2 : 2'd3;
  assign cur_byte = byte_sel(cmd_r, phase, idx);
  assign nack = ACK_CHECK && sample && state == ACK && !rd_byte && iic_sda;
  assign abort = nack || ack_err_q;
  assign iic_sda = sda_low ? 1'b0 : 1'bz;
  assign cmd.busy = state != IDLE;
  assign cmd.ack_err = ack_err_q;
  assign cmd.riic_data = riic_q;
  always_comb begin
    state_n = state;
    iic_scl = 1'b1;
    sda_low = 1'b0;
    case (state)
      IDLE: state_n = cmd.start ? START : IDLE;
      START: begin
        sda_low = quarter[1];
        state_n = slot_end ? BYTE : START;
      end
      BYTE: begin
        iic_scl = quarter[1];
        sda_low = !rd_byte && !cur_byte[~bit_cnt];
        state_n = slot_end && bit_cnt == 3'd7 ? ACK : BYTE;
      end
      ACK: begin
        iic_scl = quarter[1];
        state_n = !slot_end ? ACK : idx == last || abort ? STOP : BYTE;
      end
      STOP: begin
        iic_scl = quarter != 2'd0;
        sda_low = !quarter[1];
        state_n = !slot_end ? STOP : rd && !phase && !ack_err_q ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state <= IDLE;
      cmd_r <= '0;
      bit_cnt <= '0;
      idx <= '0;
      phase <= 1'b0;
      rx <= '0;
      riic_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd.start) begin
        cmd_r <= cmd.wdata;
        bit_cnt <= '0;
        idx <= '0;
        phase <= 1'b0;
        ack_err_q <= 1'b0;
      end
      if (state == BYTE && slot_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == ACK && slot_end) idx <= idx + 2'd1;
      if (state == STOP && slot_end) begin
        phase <= 1'b1;
        idx <= '0;
      end
      if (nack) ack_err_q <= 1'b1;
      if (state == BYTE && sample && rd_byte) begin
        rx <= {rx[5:0], iic_sda};
        if (bit_cnt == 3'd7) riic_q <= {rx, iic_sda};
      end
    end
  end
endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: scoreboard bench for sccb_master with a behavioural OV5640 slave at 0x78/0x79
module tb_sccb_master;
  localparam int QDIV = 2;
  typedef struct {
    string name;
    int len;
    logic [7:0] rdata;
    logic err;
    logic [71:0] frames;
    int nfr;
    int nst;
    int nsp;
  } exp_t;
  logic sclk = 1'b0;
  logic s_rst = 1'b1;
  logic iic_scl;
  wire iic_sda;
  logic slv_low = 1'b0;
  logic [7:0] rd_val = 8'h56;
  int nack_frame = -1;
  int n_vec = 0;
  int n_miss = 0;
  exp_t sb[$];
  sccb_master_if bus();
  pullup (iic_sda);
  assign iic_sda = slv_low ? 1'b0 : 1'bz;
  sccb_master #(.QDIV(QDIV)) dut (
    .sclk(sclk), .s_rst(s_rst), .iic_scl(iic_scl), .iic_sda(iic_sda), .cmd(bus)
  );
  always #5 sclk = ~sclk;
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_txn(input string nm, input int len, input logic [7:0] rdata, input logic err,
                            input logic [71:0] fr, input int nfr, input int nst, input int nsp);
    exp_t e;
    e.name = nm;
    e.len = len;
    e.rdata = rdata;
    e.err = err;
    e.frames = fr;
    e.nfr = nfr;
    e.nst = nst;
    e.nsp = nsp;
    sb.push_back(e);
  endtask
  task automatic issue(input logic [31:0] wd);
    bus.start = 1'b1;
    bus.wdata = wd;
    @(negedge sclk);
    bus.start = 1'b0;
    bus.wdata = 32'hDEAD_BEEF;
    chk("busy_rise", bus.busy, 1);
    chk("ack_err_clear", bus.ack_err, 0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 1000 && bus.busy; i++) @(negedge sclk);
    chk("idle_in_time", bus.busy, 0);
  endtask
  initial begin : monitor
    logic scl_p, sda_p, busy_p, scl, sda, rd_mode;
    int bitn, fidx, cyc, t_rise, nfr, nst, nsp;
    logic [7:0] sh, addr;
    logic [71:0] frames;
    exp_t e;
    scl_p = 1'b1; sda_p = 1'b1; busy_p = 1'b0;
    bitn = 0; fidx = 0; cyc = 0; t_rise = 0; nfr = 0; nst = 0; nsp = 0;
    sh = '0; addr = '0; frames = '0;
    forever begin
      @(negedge sclk);
      cyc++;
      scl = iic_scl;
      sda = iic_sda;
      if (bus.busy && !busy_p) begin
        t_rise = cyc;
        frames = '0;
        nfr = 0;
        nst = 0;
        nsp = 0;
      end
      if (scl_p && scl && sda_p && !sda) begin
        nst++;
        bitn = 0;
        fidx = 0;
        slv_low = 1'b0;
      end else if (scl_p && scl && !sda_p && sda) begin
        nsp++;
        slv_low = 1'b0;
      end else if (!scl_p && scl) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sda};
          bitn++;
        end else begin
          frames = {frames[62:0], sh, sda};
          nfr++;
          if (fidx == 0) addr = sh;
          fidx++;
          bitn = 0;
        end
      end else if (scl_p && !scl) begin
        rd_mode = fidx == 1 && addr[0];
        slv_low = bitn == 8 ? (!rd_mode && fidx != nack_frame) : (rd_mode && !rd_val[7 - bitn]);
      end
      if (!bus.busy && busy_p) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_txn: busy pulse of %0d cycles, none expected", cyc - t_rise);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_busy_len"}, cyc - t_rise, e.len);
          chk({e.name, "_riic_data"}, bus.riic_data, e.rdata);
          chk({e.name, "_ack_err"}, bus.ack_err, e.err);
          chk({e.name, "_frames"}, frames, e.frames);
          chk({e.name, "_nframes"}, nfr, e.nfr);
          chk({e.name, "_starts"}, nst, e.nst);
          chk({e.name, "_stops"}, nsp, e.nsp);
        end
      end
      scl_p = scl;
      sda_p = sda;
      busy_p = bus.busy;
    end
  end
  initial begin : stimulus
    logic seen;
    bus.start = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge sclk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    chk("rst_riic_data", bus.riic_data, 0);
    chk("rst_scl", iic_scl, 1);
    chk("rst_sda", iic_sda, 1);
    s_rst = 1'b0;
    @(negedge sclk);
    expect_txn("write", 304, 8'h00, 1'b0, {8'h78, 1'b0, 8'h31, 1'b0, 8'h03, 1'b0, 8'h11, 1'b0}, 4, 1, 1);
    issue(32'h7831_0311);
    wait_idle();
    expect_txn("read", 392, 8'h56, 1'b0,
               {8'h78, 1'b0, 8'h30, 1'b0, 8'h0A, 1'b0, 8'h79, 1'b0, 8'h56, 1'b1}, 5, 2, 2);
    issue(32'h7930_0A00);
    wait_idle();
    nack_frame = 1;
`ifdef SCCB_ACK_CHECK_EN
    expect_txn("nack", 160, 8'h56, 1'b1, {8'h78, 1'b0, 8'h31, 1'b1}, 2, 1, 1);
`else
    expect_txn("nack", 304, 8'h56, 1'b0, {8'h78, 1'b0, 8'h31, 1'b1, 8'h03, 1'b0, 8'h11, 1'b0}, 4, 1, 1);
`endif
    issue(32'h7831_0311);
    wait_idle();
    nack_frame = -1;
    expect_txn("ignore_start", 304, 8'h56, 1'b0, {8'h78, 1'b0, 8'hAB, 1'b0, 8'hCD, 1'b0, 8'h5E, 1'b0}, 4, 1, 1);
    issue(32'h78AB_CD5E);
    repeat (100) @(negedge sclk);
    bus.start = 1'b1;
    bus.wdata = 32'h79FF_FFFF;
    @(negedge sclk);
    bus.start = 1'b0;
    wait_idle();
    seen = 1'b0;
    repeat (50) begin
      @(negedge sclk);
      seen |= bus.busy;
    end
    chk("no_queued_start", seen, 0);
    expect_txn("b2b_a", 304, 8'h56, 1'b0, {8'h78, 1'b0, 8'h01, 1'b0, 8'h02, 1'b0, 8'h03, 1'b0}, 4, 1, 1);
    expect_txn("b2b_b", 304, 8'h56, 1'b0, {8'h78, 1'b0, 8'h10, 1'b0, 8'h20, 1'b0, 8'h30, 1'b0}, 4, 1, 1);
    issue(32'h7801_0203);
    wait_idle();
    issue(32'h7810_2030);
    wait_idle();
    expect_txn("reset_abort", 187, 8'h00, 1'b0, {8'h78, 1'b0, 8'h31, 1'b0}, 2, 1, 0);
    issue(32'h7831_0311);
    repeat (186) @(negedge sclk);
    s_rst = 1'b1;
    @(negedge sclk);
    chk("mid_rst_scl", iic_scl, 1);
    chk("mid_rst_sda", iic_sda, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ack_err", bus.ack_err, 0);
    chk("mid_rst_riic_data", bus.riic_data, 0);
    s_rst = 1'b0;
    @(negedge sclk);
    expect_txn("after_rst", 304, 8'h00, 1'b0, {8'h78, 1'b0, 8'h31, 1'b0, 8'h03, 1'b0, 8'h11, 1'b0}, 4, 1, 1);
    issue(32'h7831_0311);
    wait_idle();
    repeat (2) @(negedge sclk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
